// File: rtl/jesd_rx_capture_pkg.sv
// jesd_rx_capture_pkg
//   Shared types and constants for the JESD204 RX snapshot capture engine:
//   capture FSM state encoding (also the STATUS[2:0] readback value),
//   CSR word offsets and CTRL/STATUS bit positions.
package jesd_rx_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DONE    = 3'd3,
      ST_ERROR   = 3'd4
   } cap_state_e;

   localparam logic [1:0] CSR_CTRL   = 2'd0;
   localparam logic [1:0] CSR_STATUS = 2'd1;
   localparam logic [1:0] CSR_LENGTH = 2'd2;
   localparam logic [1:0] CSR_COUNT  = 2'd3;

   localparam int CTRL_ARM    = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_ALIGN  = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int STATUS_LOST = 3;

endpackage

// File: rtl/jesd_rx_capture_ram.sv
// jesd_rx_capture_ram
//   Simple dual-port capture buffer, one full link beat per word.
//   Ports:
//     clk_clk          clock
//     wr_en/wr_addr    write strobe and beat index
//     wr_data          full beat (all lanes)
//     rd_addr          beat index to read, sampled every clock
//     rd_data          registered read data, one cycle after rd_addr
//   Contents are not reset.
module jesd_rx_capture_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 128,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk_clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   import jesd_rx_capture_pkg::*;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_d;
   logic [WIDTH-1:0] rd_data_q;

   always_comb begin
      rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge clk_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/jesd_rx_capture.sv
// jesd_rx_capture
//   Snapshot capture of JESD204 RX link beats into on-chip RAM, with an
//   Avalon-MM slave for control, status and buffer readback.
//   Ports:
//     clk_clk, reset_reset_n      clock, synchronous active-low reset
//     rx_data/valid/sync/sysref   link payload, qualifier, link-up, SYSREF
//     avs_address                 MSB=0: CSR (low 2 bits); MSB=1: {beat, lane}
//     avs_read/avs_write          strobes; writes only reach the CSRs
//     avs_writedata               write data
//     avs_readdata                read data, fixed 2-cycle latency, held otherwise
//     irq                         level, high in DONE/ERROR while IRQ_EN set
//
//   state   | meaning
//   IDLE    | not capturing, waiting for ARM
//   ARMED   | waiting for link up (and SYSREF edge if ALIGN) plus a valid beat
//   CAPTURE | storing each valid beat at COUNT
//   DONE    | COUNT reached effective LENGTH
//   ERROR   | link dropped mid-capture, COUNT frozen
module jesd_rx_capture #(
   parameter int LANES  = 4,
   parameter int DEPTH  = 1024,
   localparam int AW    = $clog2(DEPTH),
   localparam int LAW   = $clog2(LANES),
   localparam int ADW   = 1 + AW + LAW
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic [LANES*32-1:0]   rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_sync,
   input  logic                  rx_sysref,
   input  logic [ADW-1:0]        avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   output logic [31:0]           avs_readdata,
   output logic                  irq
);
   import jesd_rx_capture_pkg::*;

   cap_state_e       state_q, state_d;
   logic [AW:0]      count_q, count_d;
   logic [AW:0]      length_q, length_d;
   logic             align_q, align_d;
   logic             irq_en_q, irq_en_d;
   logic             lost_q, lost_d;
   logic             seen_q, seen_d;
   logic             sysref_q, sysref_d;
   logic             rd_vld_q, rd_vld_d;
   logic             rd_buf_q, rd_buf_d;
   logic [LAW-1:0]   rd_lane_q, rd_lane_d;
   logic [31:0]      rd_csr_q, rd_csr_d;
   logic [31:0]      readdata_q, readdata_d;

   logic             csr_wr, ctrl_wr, arm, abort;
   logic             sysref_rise, align_ok;
   logic [AW:0]      eff_len, count_inc;
   logic             wr_en;
   logic [LANES*32-1:0] ram_rd_data;
   logic             unused_ok;

   assign unused_ok = ^{avs_writedata[31:AW+1]};

   assign csr_wr      = avs_write && !avs_address[ADW-1];
   assign ctrl_wr     = csr_wr && (avs_address[1:0] == CSR_CTRL);
   assign arm         = ctrl_wr && avs_writedata[CTRL_ARM];
   assign abort       = ctrl_wr && avs_writedata[CTRL_ABORT];
   assign sysref_rise = rx_sysref && !sysref_q;
   assign count_inc   = count_q + (AW+1)'(1);
   assign eff_len     = (length_q == '0 || length_q > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length_q;
   // The edge cycle itself may carry the first captured beat.
   assign align_ok    = !align_q || seen_q || (sysref_rise && rx_sync);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      lost_d   = lost_q;
      seen_d   = seen_q;
      wr_en    = 1'b0;
      sysref_d = rx_sysref;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (arm) begin
                  state_d = ST_ARMED;
                  count_d = '0;
                  lost_d  = 1'b0;
                  seen_d  = 1'b0;
               end
            end
            ST_ARMED: begin
               if (align_q && sysref_rise && rx_sync) seen_d = 1'b1;
               if (align_ok && rx_sync && rx_valid) begin
                  wr_en   = 1'b1;
                  count_d = count_inc;
                  state_d = (count_inc == eff_len) ? ST_DONE : ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               // A final beat completes the capture even if the link drops with it.
               if (rx_valid && count_inc == eff_len) begin
                  wr_en   = 1'b1;
                  count_d = count_inc;
                  state_d = ST_DONE;
               end else if (!rx_sync) begin
                  state_d = ST_ERROR;
                  lost_d  = 1'b1;
               end else if (rx_valid) begin
                  wr_en   = 1'b1;
                  count_d = count_inc;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      align_d  = align_q;
      irq_en_d = irq_en_q;
      length_d = length_q;
      if (ctrl_wr) begin
         align_d  = avs_writedata[CTRL_ALIGN];
         irq_en_d = avs_writedata[CTRL_IRQ_EN];
      end
      if (csr_wr && avs_address[1:0] == CSR_LENGTH) begin
         length_d = avs_writedata[AW:0];
      end
   end

   // Read pipeline: stage 1 snapshots the CSR value alongside the RAM read,
   // stage 2 selects lane or CSR so every address has the same latency.
   always_comb begin
      rd_vld_d  = avs_read;
      rd_buf_d  = avs_address[ADW-1];
      rd_lane_d = avs_address[LAW-1:0];
      case (avs_address[1:0])
         CSR_CTRL:   rd_csr_d = 32'({irq_en_q, align_q, 2'b00});
         CSR_STATUS: rd_csr_d = 32'({lost_q, state_q});
         CSR_LENGTH: rd_csr_d = 32'(length_q);
         default:    rd_csr_d = 32'(count_q);
      endcase
      readdata_d = readdata_q;
      if (rd_vld_q) begin
         readdata_d = rd_buf_q ? ram_rd_data[{rd_lane_q, 5'd0} +: 32] : rd_csr_q;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         length_q   <= '0;
         align_q    <= 1'b0;
         irq_en_q   <= 1'b0;
         lost_q     <= 1'b0;
         seen_q     <= 1'b0;
         sysref_q   <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_buf_q   <= 1'b0;
         rd_lane_q  <= '0;
         rd_csr_q   <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         length_q   <= length_d;
         align_q    <= align_d;
         irq_en_q   <= irq_en_d;
         lost_q     <= lost_d;
         seen_q     <= seen_d;
         sysref_q   <= sysref_d;
         rd_vld_q   <= rd_vld_d;
         rd_buf_q   <= rd_buf_d;
         rd_lane_q  <= rd_lane_d;
         rd_csr_q   <= rd_csr_d;
         readdata_q <= readdata_d;
      end
   end

   jesd_rx_capture_ram #(
      .DEPTH (DEPTH),
      .WIDTH (LANES*32)
   ) u_ram (
      .clk_clk (clk_clk),
      .wr_en   (wr_en),
      .wr_addr (count_q[AW-1:0]),
      .wr_data (rx_data),
      .rd_addr (avs_address[LAW +: AW]),
      .rd_data (ram_rd_data)
   );

   assign avs_readdata = readdata_q;
   assign irq          = irq_en_q && (state_q == ST_DONE || state_q == ST_ERROR);

endmodule

// File: tb/tb_jesd_rx_capture.sv
module tb_jesd_rx_capture;
   localparam int LANES = 4;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int LAW   = 2;
   localparam int ADW   = 1 + AW + LAW;

   localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DONE = 3, S_ERROR = 4;

   logic                clk_clk = 1'b0;
   logic                reset_reset_n = 1'b0;
   logic [LANES*32-1:0] rx_data = '0;
   logic                rx_valid = 1'b0;
   logic                rx_sync = 1'b0;
   logic                rx_sysref = 1'b0;
   logic [ADW-1:0]      avs_address = '0;
   logic                avs_read = 1'b0;
   logic                avs_write = 1'b0;
   logic [31:0]         avs_writedata = '0;
   logic [31:0]         avs_readdata;
   logic                irq;

   always #5 clk_clk = ~clk_clk;

   jesd_rx_capture dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_sync       (rx_sync),
      .rx_sysref     (rx_sysref),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .irq           (irq)
   );

   int total = 0;
   int bad   = 0;

   // Scoreboard: expected read data queued at issue, popped two cycles later.
   logic [31:0] exp_q [$];
   logic [1:0]  rd_pipe = 2'b00;

   always @(posedge clk_clk) rd_pipe <= {rd_pipe[0], avs_read};

   always @(negedge clk_clk) begin
      if (rd_pipe[1]) begin
         logic [31:0] e;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected actual=%h required=<no read pending>", avs_readdata);
         end else begin
            e = exp_q.pop_front();
            if (avs_readdata !== e) begin
               bad++;
               $display("FAIL rd_data actual=%h required=%h", avs_readdata, e);
            end
         end
      end
   end

   // Reference model: software-visible capture state kept as plain variables.
   int          m_state, m_count, m_len;
   bit          m_align, m_irqen, m_lost, m_seen, m_prev;
   logic [31:0] m_mem [DEPTH][LANES];

   function automatic int eff_len(int l);
      return (l == 0 || l > DEPTH) ? DEPTH : l;
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_count = 0; m_len = 0;
      m_align = 0; m_irqen = 0; m_lost = 0; m_seen = 0; m_prev = 0;
   endtask

   task automatic model_store(logic [LANES*32-1:0] d);
      for (int l = 0; l < LANES; l++) m_mem[m_count][l] = d[32*l +: 32];
      m_count++;
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic send_beat(bit v, bit s, bit sr, logic [LANES*32-1:0] d);
      bit rise;
      rx_valid = v; rx_sync = s; rx_sysref = sr; rx_data = d;
      rise = sr && !m_prev;
      m_prev = sr;
      if (m_state == S_ARMED) begin
         if (rise && s) m_seen = 1;
         if (s && v && (!m_align || m_seen)) begin
            model_store(d);
            m_state = (m_count == eff_len(m_len)) ? S_DONE : S_CAPTURE;
         end
      end else if (m_state == S_CAPTURE) begin
         if (v && m_count + 1 == eff_len(m_len)) begin
            model_store(d);
            m_state = S_DONE;
         end else if (!s) begin
            m_state = S_ERROR;
            m_lost  = 1;
         end else if (v) begin
            model_store(d);
         end
      end
      tick();
      rx_valid = 0; rx_sysref = 0;
      m_prev = 0;
   endtask

   task automatic csr_write(logic [1:0] a, logic [31:0] d);
      avs_address = ADW'(a); avs_writedata = d; avs_write = 1;
      if (a == 2'd0) begin
         if (d[1]) m_state = S_IDLE;
         else if (d[0] && (m_state == S_IDLE || m_state == S_DONE || m_state == S_ERROR)) begin
            m_state = S_ARMED; m_count = 0; m_lost = 0; m_seen = 0;
         end
         m_align = d[2]; m_irqen = d[3];
      end else if (a == 2'd2) begin
         m_len = int'(d[AW:0]);
      end
      tick();
      avs_write = 0;
   endtask

   task automatic rd_raw(logic [ADW-1:0] addr, logic [31:0] exp);
      exp_q.push_back(exp);
      avs_address = addr; avs_read = 1;
      tick();
      avs_read = 0;
   endtask

   task automatic rd_csr(logic [1:0] a);
      logic [31:0] e;
      case (a)
         2'd0:    e = {28'd0, m_irqen, m_align, 2'b00};
         2'd1:    e = {28'd0, m_lost, 3'(m_state)};
         2'd2:    e = 32'(m_len);
         default: e = 32'(m_count);
      endcase
      rd_raw(ADW'(a), e);
   endtask

   task automatic rd_buf(int beat, int lane);
      logic [AW-1:0]  b;
      logic [LAW-1:0] l;
      b = AW'(beat); l = LAW'(lane);
      rd_raw({1'b1, b, l}, m_mem[beat][lane]);
   endtask

   task automatic drain();
      repeat (3) tick();
   endtask

   function automatic logic [LANES*32-1:0] rand_beat();
      logic [LANES*32-1:0] d;
      for (int l = 0; l < LANES; l++) d[32*l +: 32] = $urandom;
      return d;
   endfunction

   function automatic bit exp_irq();
      return m_irqen && (m_state == S_DONE || m_state == S_ERROR);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LANES*32-1:0] d;
      logic [LANES*32-1:0] beat37;
      model_reset();
      repeat (3) tick();
      reset_reset_n = 1;
      rx_sync = 1;
      tick();

      // Reset state
      check("reset_readdata", avs_readdata, 32'h0);
      check("reset_irq", 32'(irq), 32'(exp_irq()));
      for (int a = 0; a < 4; a++) rd_csr(2'(a));
      drain();

      // 16 beats, lane n = {n, beat}
      csr_write(2'd2, 32'd16);
      csr_write(2'd0, 32'h1);
      rd_csr(2'd1);
      rd_csr(2'd2);
      drain();
      for (int b = 0; b < 16; b++) begin
         for (int l = 0; l < LANES; l++) d[32*l +: 32] = {16'(l), 16'(b)};
         send_beat(1, 1, 0, d);
      end
      rd_csr(2'd1);
      rd_csr(2'd3);
      rd_raw({1'b1, 10'd5, 2'd2}, 32'h0002_0005);
      for (int b = 0; b < 16; b++)
         for (int l = 0; l < LANES; l++) rd_buf(b, l);
      drain();
      check("irq_disabled", 32'(irq), 32'(exp_irq()));

      // LENGTH=8 with random valid gaps, IRQ_EN on
      csr_write(2'd2, 32'd8);
      csr_write(2'd0, 32'h9);
      for (int b = 0; b < 40; b++) send_beat(bit'($urandom_range(0, 1)), 1, 0, rand_beat());
      rd_csr(2'd1);
      rd_csr(2'd3);
      rd_csr(2'd0);
      for (int b = 0; b < 8; b++)
         for (int l = 0; l < LANES; l++) rd_buf(b, l);
      drain();
      check("irq_done", 32'(irq), 32'(exp_irq()));

      // ALIGN: early SYSREF edge while link down is ignored, edge at beat 37 aligns
      beat37 = '0;
      csr_write(2'd2, 32'd4);
      csr_write(2'd0, 32'hD);
      for (int b = 0; b < 45; b++) begin
         d = rand_beat();
         if (b == 37) beat37 = d;
         send_beat(1, !(b >= 4 && b < 9), (b >= 5 && b < 8) || (b >= 37 && b < 40), d);
      end
      rd_raw({1'b1, 10'd0, 2'd0}, beat37[31:0]);
      rd_raw({1'b1, 10'd0, 2'd3}, beat37[127:96]);
      rd_csr(2'd1);
      rd_csr(2'd3);
      for (int l = 0; l < LANES; l++) rd_buf(3, l);
      drain();

      // Link lost after 5 beats with LENGTH=10
      csr_write(2'd2, 32'd10);
      csr_write(2'd0, 32'h9);
      for (int b = 0; b < 5; b++) send_beat(1, 1, 0, rand_beat());
      send_beat(0, 0, 0, '0);
      rx_sync = 0;
      rd_raw(ADW'(1), 32'hC);
      rd_raw(ADW'(3), 32'd5);
      rd_csr(2'd1);
      drain();
      check("irq_error", 32'(irq), 32'(exp_irq()));
      check("irq_error_const", 32'(irq), 32'h1);

      // LENGTH=0 captures DEPTH beats; extra beats afterwards are not stored
      rx_sync = 1;
      csr_write(2'd2, 32'd0);
      csr_write(2'd0, 32'h1);
      for (int b = 0; b < DEPTH + 6; b++) send_beat(1, 1, 0, rand_beat());
      rd_csr(2'd1);
      rd_raw(ADW'(3), 32'(DEPTH));
      rd_buf(0, 0); rd_buf(1, 3); rd_buf(511, 2); rd_buf(1022, 1); rd_buf(1023, 0);
      for (int i = 0; i < 8; i++) rd_buf($urandom_range(0, DEPTH-1), $urandom_range(0, LANES-1));
      drain();

      // ARM and ABORT together: ABORT wins
      csr_write(2'd0, 32'h3);
      rd_csr(2'd1);
      rd_raw(ADW'(1), 32'h0);
      drain();

      // Reset during CAPTURE
      csr_write(2'd2, 32'd200);
      csr_write(2'd0, 32'h9);
      rd_csr(2'd1);
      for (int b = 0; b < 5; b++) send_beat(1, 1, 0, rand_beat());
      reset_reset_n = 0;
      tick();
      model_reset();
      check("rst_mid_readdata", avs_readdata, 32'h0);
      check("rst_mid_irq", 32'(irq), 32'h0);
      reset_reset_n = 1;
      tick();
      for (int a = 0; a < 4; a++) rd_csr(2'(a));
      drain();

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rd_pending actual=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
